// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester memory arbiter, fixed LSU priority, one outstanding request with timeout
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_owner;
  logic [7:0]  r_cnt;
  logic        w_idle, w_done, w_timeout;
  // State register, request latch, timeout counter and per-requester result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_cnt     <= 8'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wmask <= 4'h0;
      ifu_rdata <= 32'h0;
      ifu_err   <= 1'b0;
      lsu_rdata <= 32'h0;
      lsu_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (ifu_gnt || lsu_gnt) begin
        r_owner   <= lsu_gnt;
        r_cnt     <= 8'd0;
        mem_we    <= lsu_gnt & lsu_we;
        mem_addr  <= lsu_gnt ? lsu_addr : ifu_addr;
        mem_wdata <= lsu_gnt ? lsu_wdata : 32'h0;
        mem_wmask <= lsu_gnt ? lsu_wmask : 4'h0;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_done && r_owner) begin
        lsu_rdata <= mem_resp ? mem_rdata : 32'h0;
        lsu_err   <= !mem_resp;
      end
      if (w_done && !r_owner) begin
        ifu_rdata <= mem_resp ? mem_rdata : 32'h0;
        ifu_err   <= !mem_resp;
      end
    end
  end
  // Next state, grants and handshake outputs; a response in the timeout cycle beats the timeout
  always_comb begin
    w_idle     = rst && r_state == IDLE;
    lsu_gnt    = w_idle & lsu_req;
    ifu_gnt    = w_idle & ifu_req & ~lsu_req;
    w_timeout  = r_cnt == 8'(TIMEOUT - 1);
    w_done     = r_state == BUSY && (mem_resp || w_timeout);
    mem_req    = r_state == BUSY;
    ifu_rvalid = r_state == RESP && !r_owner;
    lsu_rvalid = r_state == RESP && r_owner;
    w_next     = r_state == IDLE ? ((ifu_req || lsu_req) ? BUSY : IDLE) :
                 r_state == BUSY ? (w_done ? RESP : BUSY) : IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven transactions with a response scoreboard plus reset/priority/stray-response sequences
module tb_mem_arbiter;
  localparam int TO = 4;
  logic        clk = 0, rst = 0;
  logic        ifu_req = 0, ifu_gnt, ifu_rvalid, ifu_err;
  logic [31:0] ifu_addr = 0, ifu_rdata;
  logic        lsu_req = 0, lsu_we = 0, lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
  logic [3:0]  lsu_wmask = 0;
  logic        mem_req, mem_we, mem_resp = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wmask;
  int checks = 0, errors = 0;

  typedef struct {
    logic        lsu;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          dly;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  typedef struct {
    logic        lsu;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  vec_t vecs[6];

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask

  // Scoreboard: every rvalid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (ifu_rvalid || lsu_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rvalid got ifu=%b lsu=%b exp none", ifu_rvalid, lsu_rvalid);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rvalid_owner", {30'h0, ifu_rvalid, lsu_rvalid}, e.lsu ? 32'h1 : 32'h2);
        chk("rdata", e.lsu ? lsu_rdata : ifu_rdata, e.rdata);
        chk("err", {31'h0, e.lsu ? lsu_err : ifu_err}, {31'h0, e.err});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge with the DUT in IDLE; returns in the following IDLE cycle
  task automatic do_txn(input vec_t v, input logic both);
    ifu_req   = !v.lsu || both;
    ifu_addr  = v.lsu ? 32'h1111_2222 : v.addr;
    lsu_req   = v.lsu;
    lsu_we    = v.lsu ? v.we : 1'b1;
    lsu_addr  = v.lsu ? v.addr : 32'h3333_4444;
    lsu_wdata = v.lsu ? v.wdata : 32'hFFFF_FFFF;
    lsu_wmask = v.lsu ? v.wmask : 4'hF;
    #1;
    chk("gnt", {30'h0, ifu_gnt, lsu_gnt}, v.lsu ? 32'h1 : 32'h2);
    exp_q.push_back('{v.lsu, v.exp_rdata, v.exp_err});
    tick();
    ifu_req = both;
    lsu_req = 0;
    chk("mem_we", {31'h0, mem_we}, {31'h0, v.lsu & v.we});
    chk("mem_wmask", {28'h0, mem_wmask}, {28'h0, v.lsu ? v.wmask : 4'h0});
    if (v.lsu) chk("mem_wdata", mem_wdata, v.wdata);
    for (int i = 0; i < TO; i++) begin
      chk("busy_mem_req", {31'h0, mem_req}, 32'h1);
      chk("busy_mem_addr", mem_addr, v.addr);
      chk("busy_rvalid", {30'h0, ifu_rvalid, lsu_rvalid}, 32'h0);
      if (both) chk("busy_ifu_gnt", {31'h0, ifu_gnt}, 32'h0);
      if (i == v.dly) begin
        mem_resp  = 1;
        mem_rdata = v.rdata;
      end
      tick();
      mem_resp  = 0;
      mem_rdata = 0;
      if (i == v.dly) break;
    end
    chk("resp_mem_req", {31'h0, mem_req}, 32'h0);
    if (both) chk("resp_ifu_gnt", {31'h0, ifu_gnt}, 32'h0);
    tick();
    chk("hold_rdata", v.lsu ? lsu_rdata : ifu_rdata, v.exp_rdata);
    chk("hold_err", {31'h0, v.lsu ? lsu_err : ifu_err}, {31'h0, v.exp_err});
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 3, 32'h0010_0073, 32'h0010_0073, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_2004, 32'h0, 4'hF, 0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h8000_0100, 32'h0, 4'h0, TO, 32'h1234_5678, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h8000_0104, 32'h0, 4'h0, 2, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_3000, 32'h0, 4'hF, TO, 32'h5555_5555, 32'h0, 1'b1};

    ifu_req = 1;
    lsu_req = 1;
    tick();
    tick();
    chk("rst_gnt", {30'h0, ifu_gnt, lsu_gnt}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_fields", {mem_we, mem_wmask, mem_addr | mem_wdata}, 37'h0);
    chk("rst_rvalid", {30'h0, ifu_rvalid, lsu_rvalid}, 32'h0);
    chk("rst_rdata", ifu_rdata | lsu_rdata, 32'h0);
    chk("rst_err", {30'h0, ifu_err, lsu_err}, 32'h0);
    ifu_req = 0;
    lsu_req = 0;
    rst = 1;
    tick();

    foreach (vecs[k]) do_txn(vecs[k], 1'b0);

    mem_resp  = 1;
    mem_rdata = 32'hFFFF_0000;
    tick();
    mem_resp  = 0;
    mem_rdata = 0;
    chk("stray_mem_req", {31'h0, mem_req}, 32'h0);
    chk("stray_lsu_err", {31'h0, lsu_err}, 32'h1);
    chk("stray_lsu_rdata", lsu_rdata, 32'h0);
    tick();
    chk("stray_rvalid", {30'h0, ifu_rvalid, lsu_rvalid}, 32'h0);

    do_txn(vecs[2], 1'b1);
    chk("held_ifu_gnt", {30'h0, ifu_gnt, lsu_gnt}, 32'h2);
    do_txn(vecs[0], 1'b0);

    ifu_req  = 1;
    ifu_addr = 32'h8000_0200;
    #1;
    chk("abort_gnt", {31'h0, ifu_gnt}, 32'h1);
    tick();
    ifu_req = 0;
    chk("abort_busy", {31'h0, mem_req}, 32'h1);
    rst = 0;
    tick();
    rst = 1;
    chk("abort_mem_req", {31'h0, mem_req}, 32'h0);
    chk("abort_rvalid", {30'h0, ifu_rvalid, lsu_rvalid}, 32'h0);
    chk("abort_fields", {mem_we, mem_wmask, mem_addr | mem_wdata}, 37'h0);
    chk("abort_rdata", ifu_rdata | lsu_rdata, 32'h0);
    tick();
    chk("abort_after_rvalid", {30'h0, ifu_rvalid, lsu_rvalid}, 32'h0);
    chk("abort_after_mem_req", {31'h0, mem_req}, 32'h0);
    tick();
    do_txn(vecs[4], 1'b0);

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
